// File: rtl/sr_feeder_pkg.sv
// Shared types and defaults for the shift-register input feeder.
// Defaults assume a 100 MHz CLK and a CLK/2^25 slow clock on the SR4RE.
package sr_feeder_pkg;

    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_HOLD_CYCLES     = 33554432;

    localparam int NUM_IN   = 3;
    localparam int IN_SHIFT = 0;
    localparam int IN_CLR   = 1;
    localparam int IN_DATA  = 2;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SHIFT_HOLD = 2'd1,
        CLR_HOLD   = 2'd2,
        GAP        = 2'd3
    } state_t;

endpackage

// File: rtl/sr_input_feeder_debounce_edge.sv
// One conditioned board input: 2-flop synchronizer, debounce counter, and a
// registered 1-cycle rise pulse issued on the same edge the stable level flips.
module debounce_edge
    import sr_feeder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic CLK,
    input  logic R,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            rise  <= 1'b0;
            // any cycle that agrees with the stable level restarts the count
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= sync2;
                rise  <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sr_input_feeder.sv
// Conditions the shift/clear buttons and data switch, then issues SR_CE/SR_R
// strobes one slow-clock period long with a one-deep queue for early presses.
module sr_input_feeder
    import sr_feeder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
    input  logic CLK,
    input  logic R,
    input  logic BTN_SHIFT,
    input  logic BTN_CLR,
    input  logic SW_DATA,
    output logic SR_CE,
    output logic SR_SLI,
    output logic SR_R,
    output logic PENDING
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);

    logic [NUM_IN-1:0] raw;
    logic [NUM_IN-1:0] lvl;
    logic [NUM_IN-1:0] rise;
    logic              unused_in;

    assign raw       = {SW_DATA, BTN_CLR, BTN_SHIFT};
    assign unused_in = ^{lvl[IN_CLR], lvl[IN_SHIFT], rise[IN_DATA]};

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .CLK  (CLK),
            .R    (R),
            .din  (raw[i]),
            .level(lvl[i]),
            .rise (rise[i])
        );
    end

    logic shift_rise, clr_rise, data_lvl;
    assign shift_rise = rise[IN_SHIFT];
    assign clr_rise   = rise[IN_CLR];
    assign data_lvl   = lvl[IN_DATA];

    state_t        state_q, state_n;
    logic [HW-1:0] hold_q, hold_n;
    logic          pend_q, pend_n;
    logic          pbit_q, pbit_n;
    logic          clrq_q, clrq_n;
    logic          sli_q, sli_n;

    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            state_q <= IDLE;
            hold_q  <= '0;
            pend_q  <= 1'b0;
            pbit_q  <= 1'b0;
            clrq_q  <= 1'b0;
            sli_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            hold_q  <= hold_n;
            pend_q  <= pend_n;
            pbit_q  <= pbit_n;
            clrq_q  <= clrq_n;
            sli_q   <= sli_n;
        end
    end

    always_comb begin
        state_n = state_q;
        hold_n  = hold_q;
        pend_n  = pend_q;
        pbit_n  = pbit_q;
        clrq_n  = clrq_q;
        sli_n   = sli_q;
        case (state_q)
            IDLE: begin
                hold_n = '0;
                if (clr_rise) begin
                    state_n = CLR_HOLD;
                end else if (shift_rise) begin
                    state_n = SHIFT_HOLD;
                    sli_n   = data_lvl;
                end
            end
            SHIFT_HOLD, CLR_HOLD: begin
                if (shift_rise && !pend_q) begin
                    pend_n = 1'b1;
                    pbit_n = data_lvl;
                end
                if (clr_rise && state_q == SHIFT_HOLD) clrq_n = 1'b1;
                if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                    hold_n  = '0;
                    state_n = GAP;
                end else begin
                    hold_n = hold_q + 1'b1;
                end
            end
            GAP: begin
                hold_n = '0;
                // a queued clear wins and throws away any queued shift
                if (clrq_q || clr_rise) begin
                    state_n = CLR_HOLD;
                    clrq_n  = 1'b0;
                    pend_n  = 1'b0;
                end else if (pend_q || shift_rise) begin
                    state_n = SHIFT_HOLD;
                    pend_n  = 1'b0;
                    sli_n   = pend_q ? pbit_q : data_lvl;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign SR_CE   = (state_q == SHIFT_HOLD);
    assign SR_R    = (state_q == CLR_HOLD);
    assign SR_SLI  = sli_q;
    assign PENDING = pend_q;

endmodule

// File: tb/tb_sr_input_feeder.sv
// Bench for sr_input_feeder with short debounce/hold values: directed scenarios
// plus random button activity against a window-based debounce and strobe-timeline model.
module tb_sr_input_feeder;

    localparam int D = 4;
    localparam int H = 8;

    logic CLK = 1'b0;
    logic R = 1'b1;
    logic BTN_SHIFT = 1'b0;
    logic BTN_CLR = 1'b0;
    logic SW_DATA = 1'b0;
    logic SR_CE, SR_SLI, SR_R, PENDING;

    int total = 0;
    int bad = 0;

    sr_input_feeder #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
        .CLK(CLK), .R(R), .BTN_SHIFT(BTN_SHIFT), .BTN_CLR(BTN_CLR), .SW_DATA(SW_DATA),
        .SR_CE(SR_CE), .SR_SLI(SR_SLI), .SR_R(SR_R), .PENDING(PENDING)
    );

    always #5 CLK = ~CLK;

    // reference model: input sample history, strobe timeline, queued requests
    logic [D+1:0] win [3] = '{default: '0};
    logic [2:0] m_lvl = '0;
    logic [2:0] m_rise = '0;
    int   m_n = 0;
    int   m_kind = 0;           // 0 idle, 1 shift strobe, 2 clear strobe
    int   m_start = 0;
    logic m_pend = 0, m_pbit = 0, m_clrq = 0, m_sli = 0;
    logic e_ce = 0, e_r = 0, e_sli = 0, e_pend = 0;

    task automatic m_reset();
        for (int i = 0; i < 3; i++) win[i] = '0;
        m_lvl = '0; m_rise = '0; m_n = 0; m_kind = 0; m_start = 0;
        m_pend = 0; m_pbit = 0; m_clrq = 0; m_sli = 0;
        e_ce = 0; e_r = 0; e_sli = 0; e_pend = 0;
    endtask

    task automatic m_step();
        logic [2:0] raw;
        logic all_diff;
        logic in_gap;
        m_n++;
        // rises/levels in m_rise/m_lvl belong to the cycle just ended
        if (m_kind == 0) begin
            if (m_rise[1]) begin m_kind = 2; m_start = m_n; end
            else if (m_rise[0]) begin m_kind = 1; m_start = m_n; m_sli = m_lvl[2]; end
        end else begin
            in_gap = (m_n - 1 == m_start + H);
            if (m_rise[0] && !m_pend) begin m_pend = 1; m_pbit = m_lvl[2]; end
            if (m_rise[1] && (m_kind == 1 || in_gap)) m_clrq = 1;
            if (in_gap) begin
                if (m_clrq) begin m_kind = 2; m_start = m_n; m_clrq = 0; m_pend = 0; end
                else if (m_pend) begin m_kind = 1; m_start = m_n; m_sli = m_pbit; m_pend = 0; end
                else m_kind = 0;
            end
        end
        e_ce = (m_kind == 1) && (m_n < m_start + H);
        e_r  = (m_kind == 2) && (m_n < m_start + H);
        e_sli = m_sli;
        e_pend = m_pend;
        // a level flips once the D samples seen two cycles late all disagree with it
        raw = {SW_DATA, BTN_CLR, BTN_SHIFT};
        for (int i = 0; i < 3; i++) begin
            win[i] = {win[i][D:0], raw[i]};
            all_diff = 1'b1;
            for (int k = 2; k <= D + 1; k++) if (win[i][k] == m_lvl[i]) all_diff = 1'b0;
            m_rise[i] = 1'b0;
            if (all_diff) begin m_lvl[i] = ~m_lvl[i]; m_rise[i] = m_lvl[i]; end
        end
    endtask

    initial forever begin
        @(posedge CLK or posedge R);
        if (R) m_reset(); else m_step();
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // per-cycle statistics and an SR4RE model clocked at CLK/8
    int ncyc = 0;
    int ce_str, ce_hi, ce_at0, ce_at, r_str, r_hi, r_at, pend_hi;
    logic sli_first, sli_last, ce_prev = 0, r_prev = 0;
    logic [3:0] q_sr = '0;
    int sdiv = 0;

    task automatic clr_stats();
        ce_str = 0; ce_hi = 0; ce_at0 = -1; ce_at = -1;
        r_str = 0; r_hi = 0; r_at = -1; pend_hi = 0;
        sli_first = 0; sli_last = 0;
    endtask

    task automatic tick();
        @(negedge CLK);
        ncyc++;
        chk("ce", 32'(SR_CE), 32'(e_ce));
        chk("r", 32'(SR_R), 32'(e_r));
        chk("sli", 32'(SR_SLI), 32'(e_sli));
        chk("pending", 32'(PENDING), 32'(e_pend));
        if (SR_CE && !ce_prev) begin
            ce_str++;
            if (ce_str == 1) begin ce_at0 = ncyc; sli_first = SR_SLI; end
            ce_at = ncyc; sli_last = SR_SLI;
        end
        if (SR_R && !r_prev) begin r_str++; r_at = ncyc; end
        if (SR_CE) ce_hi++;
        if (SR_R) r_hi++;
        if (PENDING) pend_hi++;
        ce_prev = SR_CE; r_prev = SR_R;
        if (R) begin
            q_sr = '0; sdiv = 0;
        end else begin
            if (sdiv == 7) begin
                if (SR_R) q_sr = '0;
                else if (SR_CE) q_sr = {q_sr[2:0], SR_SLI};
            end
            sdiv = (sdiv + 1) % 8;
        end
    endtask

    initial begin
        int t0;
        logic [3:0] bits;
        clr_stats();
        // reset state
        R = 1'b1;
        tick(); tick();
        chk("rst_out", 32'({SR_CE, SR_SLI, SR_R, PENDING}), 0);
        R = 1'b0;

        // 1: clean press with data 1
        SW_DATA = 1'b1;
        repeat (10) tick();
        clr_stats(); t0 = ncyc;
        BTN_SHIFT = 1'b1;
        repeat (12) tick();
        BTN_SHIFT = 1'b0;
        repeat (12) tick();
        chk("t1_start", ce_at - t0, 7);
        chk("t1_len", ce_hi, 8);
        chk("t1_count", ce_str, 1);
        chk("t1_sli", 32'(sli_first), 1);

        // 2: bouncing for 20 cycles, then held
        clr_stats();
        for (int k = 0; k < 10; k++) begin
            BTN_SHIFT = ~BTN_SHIFT;
            tick(); tick();
        end
        chk("t2_bounce_quiet", ce_str, 0);
        t0 = ncyc;
        BTN_SHIFT = 1'b1;
        repeat (20) tick();
        BTN_SHIFT = 1'b0;
        repeat (12) tick();
        chk("t2_count", ce_str, 1);
        chk("t2_start", ce_at - t0, 7);

        // 3: second press lands during the first strobe
        SW_DATA = 1'b0;
        repeat (10) tick();
        clr_stats(); t0 = ncyc;
        BTN_SHIFT = 1'b1;
        repeat (4) tick();
        BTN_SHIFT = 1'b0; SW_DATA = 1'b1;
        repeat (4) tick();
        BTN_SHIFT = 1'b1;
        repeat (30) tick();
        BTN_SHIFT = 1'b0;
        repeat (12) tick();
        chk("t3_count", ce_str, 2);
        chk("t3_len", ce_hi, 16);
        chk("t3_sli0", 32'(sli_first), 0);
        chk("t3_sli1", 32'(sli_last), 1);
        chk("t3_gap", ce_at - ce_at0, 9);
        chk("t3_pend_seen", pend_hi, 1);
        chk("t3_pend_end", 32'(PENDING), 0);

        // 4a: shift and clear rise together
        clr_stats(); t0 = ncyc;
        BTN_SHIFT = 1'b1; BTN_CLR = 1'b1;
        repeat (20) tick();
        BTN_SHIFT = 1'b0; BTN_CLR = 1'b0;
        repeat (12) tick();
        chk("t4_r_count", r_str, 1);
        chk("t4_r_len", r_hi, 8);
        chk("t4_r_start", r_at - t0, 7);
        chk("t4_no_ce", ce_str, 0);

        // 4b: clear arrives during a shift strobe with a shift already queued
        clr_stats(); t0 = ncyc;
        BTN_SHIFT = 1'b1;
        repeat (4) tick();
        BTN_SHIFT = 1'b0;
        repeat (4) tick();
        BTN_SHIFT = 1'b1; BTN_CLR = 1'b1;
        repeat (30) tick();
        BTN_SHIFT = 1'b0; BTN_CLR = 1'b0;
        repeat (12) tick();
        chk("t4b_ce_count", ce_str, 1);
        chk("t4b_ce_len", ce_hi, 8);
        chk("t4b_r_count", r_str, 1);
        chk("t4b_r_start", r_at - t0, 16);
        chk("t4b_pend_seen", pend_hi, 1);
        chk("t4b_pend_end", 32'(PENDING), 0);

        // 5: reset in the middle of a strobe
        clr_stats();
        BTN_SHIFT = 1'b1;
        repeat (10) tick();
        chk("t5_pre_ce", 32'(SR_CE), 1);
        R = 1'b1;
        #1;
        chk("t5_async_out", 32'({SR_CE, SR_SLI, SR_R, PENDING}), 0);
        BTN_SHIFT = 1'b0;
        repeat (3) tick();
        R = 1'b0;
        clr_stats();
        repeat (20) tick();
        chk("t5_no_ce", ce_str, 0);
        chk("t5_no_r", r_str, 0);

        // 6: four presses into the SR4RE model
        R = 1'b1;
        tick();
        R = 1'b0;
        bits = 4'b1011;
        for (int k = 3; k >= 0; k--) begin
            SW_DATA = bits[k];
            repeat (8) tick();
            BTN_SHIFT = 1'b1;
            repeat (8) tick();
            BTN_SHIFT = 1'b0;
            repeat (16) tick();
        end
        chk("t6_q", 32'(q_sr), 32'hb);

        // random button and switch activity
        for (int it = 0; it < 200; it++) begin
            BTN_SHIFT = 1'($urandom_range(0, 1));
            BTN_CLR = ($urandom_range(0, 5) == 0);
            SW_DATA = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 10)) tick();
        end
        BTN_SHIFT = 1'b0; BTN_CLR = 1'b0;
        repeat (40) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
